pick_seq: RTL

Frame sequencer for the pixel packet picker. It issues one `go` per line, counts the valid pixels returned on each line, and writes them to a line buffer at a linear address. It reports frame completion, short-line errors and, optionally, sync-search timeouts. It sits between the capture control registers and the picker/line-buffer pair, all in the CLK domain.

---
 rtl/pick_seq.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/pick_seq.sv
// Frame sequencer: arms the pixel picker once per line and writes the returned pixels
// to the line buffer at line*numPixel+pixel. Define PICK_SEQ_TIMEOUT_EN for the WAIT timeout.
module pick_seq #(
    parameter int pixelWidth    = 16,
    parameter int numPixel      = 16,
    parameter int numLine       = 8,
    parameter int timeoutCycles = 1024
) (
    input  logic                                  CLK,
    input  logic                                  nRST,
    input  logic                                  start,
    input  logic                                  abort,
    input  logic                                  pick_valid,
    input  logic [pixelWidth-1:0]                 pick_data,
    output logic                                  go,
    output logic                                  wr_en,
    output logic [$clog2(numLine*numPixel)-1:0]   wr_addr,
    output logic [pixelWidth-1:0]                 wr_data,
    output logic                                  busy,
    output logic                                  frame_done,
    output logic                                  line_err,
    output logic                                  timeout_err
);

    // state | meaning
    // IDLE  | no frame in progress, counters held at zero
    // ARM   | go pulse to the picker for the current line
    // WAIT  | waiting for the first valid pixel of the line
    // LINE  | collecting the remaining pixels of the line
    // NEXT  | line complete, advance line or finish frame
    // DONE  | frame_done pulse
    // ERR   | short line or timeout, held until start

    localparam int AW = $clog2(numLine * numPixel);
    localparam int PW = $clog2(numPixel);
    localparam int LW = (numLine > 1) ? $clog2(numLine) : 1;

    typedef enum logic [2:0] {IDLE, ARM, WAIT, LINE, NEXT, DONE, ERR} state_t;

    state_t        state;
    logic [PW-1:0] pix_cnt;
    logic [LW-1:0] line_cnt;
    logic [AW-1:0] pix_addr;

    assign pix_addr = AW'(line_cnt) * AW'(numPixel) + AW'(pix_cnt);

`ifdef PICK_SEQ_TIMEOUT_EN
    localparam int TW = (timeoutCycles > 1) ? $clog2(timeoutCycles) : 1;
    logic [TW-1:0] wait_tmr;
`else
    assign timeout_err = 1'b0;
`endif

    // Outputs are registered: each one is set on the edge that enters the state it belongs to.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            pix_cnt    <= '0;
            line_cnt   <= '0;
            go         <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            line_err   <= 1'b0;
`ifdef PICK_SEQ_TIMEOUT_EN
            timeout_err <= 1'b0;
            wait_tmr    <= '0;
`endif
        end else begin
            go         <= 1'b0;
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            if (abort && state != IDLE) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        pix_cnt  <= '0;
                        line_cnt <= '0;
                        if (start && !abort) begin
                            state <= ARM;
                            go    <= 1'b1;
                            busy  <= 1'b1;
                        end
                    end
                    ARM: begin
                        state <= WAIT;
`ifdef PICK_SEQ_TIMEOUT_EN
                        wait_tmr <= TW'(timeoutCycles - 1);
`endif
                    end
                    WAIT: begin
                        if (pick_valid) begin
                            wr_en   <= 1'b1;
                            wr_addr <= pix_addr;
                            wr_data <= pick_data;
                            pix_cnt <= PW'(1);
                            state   <= LINE;
                        end
`ifdef PICK_SEQ_TIMEOUT_EN
                        else if (wait_tmr == '0) begin
                            timeout_err <= 1'b1;
                            busy        <= 1'b0;
                            state       <= ERR;
                        end else begin
                            wait_tmr <= wait_tmr - 1'b1;
                        end
`endif
                    end
                    LINE: begin
                        if (pick_valid) begin
                            wr_en   <= 1'b1;
                            wr_addr <= pix_addr;
                            wr_data <= pick_data;
                            if (pix_cnt == PW'(numPixel - 1)) begin
                                state <= NEXT;
                            end else begin
                                pix_cnt <= pix_cnt + 1'b1;
                            end
                        end else begin
                            line_err <= 1'b1;
                            busy     <= 1'b0;
                            state    <= ERR;
                        end
                    end
                    NEXT: begin
                        pix_cnt <= '0;
                        if (line_cnt == LW'(numLine - 1)) begin
                            frame_done <= 1'b1;
                            state      <= DONE;
                        end else begin
                            line_cnt <= line_cnt + 1'b1;
                            go       <= 1'b1;
                            state    <= ARM;
                        end
                    end
                    DONE: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    ERR: begin
                        if (start) begin
                            line_err <= 1'b0;
`ifdef PICK_SEQ_TIMEOUT_EN
                            timeout_err <= 1'b0;
`endif
                            pix_cnt  <= '0;
                            line_cnt <= '0;
                            go       <= 1'b1;
                            busy     <= 1'b1;
                            state    <= ARM;
                        end
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
